// File: rtl/codeword_latency_meter_pkg.sv
// Shared constants and FSM encoding for codeword_latency_meter.
`ifndef CODEWORD_LATENCY_METER_PKG_SV
`define CODEWORD_LATENCY_METER_PKG_SV
package codeword_latency_meter_pkg;

    localparam int unsigned DEF_CNT_LEN = 10;
    localparam int unsigned DEF_CLK_CNT = 1023;
    localparam int unsigned DEF_LAT_LEN = 20;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_PTR_LEN = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } meter_state_e;

endpackage
`endif

// File: rtl/codeword_latency_meter_latency_stamp_fifo.sv
// Synchronous DEPTH x LAT_LEN stamp FIFO; head is read combinationally,
// and push+pop in the same cycle is accepted even when full.
module latency_stamp_fifo
    import codeword_latency_meter_pkg::*;
#(
    parameter int unsigned LAT_LEN = DEF_LAT_LEN,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned PTR_LEN = DEF_PTR_LEN
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic [LAT_LEN-1:0] din,
    output logic [LAT_LEN-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [PTR_LEN:0]   count
);

    logic [LAT_LEN-1:0] mem [DEPTH];
    logic [PTR_LEN-1:0] wr_ptr;
    logic [PTR_LEN-1:0] rd_ptr;
    logic [PTR_LEN:0]   cnt_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (cnt_q == (PTR_LEN+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_LEN'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_LEN'(1);
            cnt_q <= cnt_q + (PTR_LEN+1)'(do_push) - (PTR_LEN+1)'(do_pop);
        end
    end

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !srst && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/codeword_latency_meter.sv
// Per-codeword decode latency meter for the BCH decoder test harness.
// Optional min/max tracking is built only when LAT_MINMAX_EN is defined;
// otherwise out_lat_min/out_lat_max are tied to zero.
module codeword_latency_meter
    import codeword_latency_meter_pkg::*;
#(
    parameter int unsigned        CNT_LEN = DEF_CNT_LEN,
    parameter logic [CNT_LEN-1:0] CLK_CNT = CNT_LEN'(DEF_CLK_CNT),
    parameter int unsigned        LAT_LEN = DEF_LAT_LEN,
    parameter int unsigned        DEPTH   = DEF_DEPTH,
    parameter int unsigned        PTR_LEN = DEF_PTR_LEN
) (
    input  logic               clk,
    input  logic               in_Srst,
    input  logic               in_en,
    input  logic               in_clr,
    input  logic [CNT_LEN-1:0] in_clk_cnt,
    input  logic [CNT_LEN-1:0] in_clk_cycle,
    input  logic               in_start,
    input  logic               in_done,
    output logic               out_lat_valid,
    output logic [LAT_LEN-1:0] out_latency,
    output logic [LAT_LEN-1:0] out_lat_min,
    output logic [LAT_LEN-1:0] out_lat_max,
    output logic [PTR_LEN:0]   out_inflight,
    output logic               out_ovf,
    output logic               out_udf,
    output logic               out_fault
);

    meter_state_e       state;
    logic [LAT_LEN-1:0] stamp_c;
    logic [LAT_LEN-1:0] lat_c;
    logic [LAT_LEN-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PTR_LEN:0]   fifo_count;
    logic               start_ev;
    logic               done_ev;
    logic               push_c;
    logic               pop_c;
    logic               clr_c;
    logic               ovf_c;
    logic               udf_c;

    // Timestamp against the upstream counter; events during counter idle are dropped.
    assign stamp_c  = LAT_LEN'(in_clk_cycle) * LAT_LEN'(CLK_CNT) + LAT_LEN'(in_clk_cnt);
    assign start_ev = in_en && in_start && (in_clk_cnt != '0);
    assign done_ev  = in_en && in_done  && (in_clk_cnt != '0);
    assign lat_c    = stamp_c - fifo_head;

    // Event decode: clear wins, done is judged against existing entries first.
    always_comb begin
        push_c = 1'b0;
        pop_c  = 1'b0;
        clr_c  = 1'b0;
        ovf_c  = 1'b0;
        udf_c  = 1'b0;
        if (in_en) begin
            if (in_clr) begin
                clr_c = 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (done_ev)       udf_c  = 1'b1;
                        else if (start_ev) push_c = 1'b1;
                    end
                    RUN: begin
                        pop_c = done_ev && !fifo_empty;
                        if (start_ev) begin
                            if (fifo_full && !done_ev) ovf_c  = 1'b1;
                            else                       push_c = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    latency_stamp_fifo #(
        .LAT_LEN (LAT_LEN),
        .DEPTH   (DEPTH),
        .PTR_LEN (PTR_LEN)
    ) u_fifo (
        .clk   (clk),
        .srst  (in_Srst),
        .clr   (clr_c),
        .push  (push_c),
        .pop   (pop_c),
        .din   (stamp_c),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_inflight = fifo_count;

    // Control FSM with registered flags and latency result.
    always_ff @(posedge clk) begin
        if (in_Srst) begin
            state         <= IDLE;
            out_lat_valid <= 1'b0;
            out_latency   <= '0;
            out_ovf       <= 1'b0;
            out_udf       <= 1'b0;
            out_fault     <= 1'b0;
        end else begin
            out_lat_valid <= pop_c;
            if (pop_c) out_latency <= lat_c;
            if (clr_c) begin
                state     <= IDLE;
                out_ovf   <= 1'b0;
                out_udf   <= 1'b0;
                out_fault <= 1'b0;
            end else if (in_en) begin
                case (state)
                    IDLE: begin
                        if (udf_c) begin
                            state     <= FAULT;
                            out_udf   <= 1'b1;
                            out_fault <= 1'b1;
                        end else if (push_c) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (ovf_c) begin
                            state     <= FAULT;
                            out_ovf   <= 1'b1;
                            out_fault <= 1'b1;
                        end else if (pop_c && !push_c &&
                                     fifo_count == (PTR_LEN+1)'(1)) begin
                            state <= IDLE;
                        end
                    end
                    FAULT: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LAT_MINMAX_EN
    logic [LAT_LEN-1:0] lat_min_q;
    logic [LAT_LEN-1:0] lat_max_q;

    // Running extremes, visible together with the latency pulse.
    always_ff @(posedge clk) begin
        if (in_Srst || clr_c) begin
            lat_min_q <= '1;
            lat_max_q <= '0;
        end else if (pop_c) begin
            if (lat_c < lat_min_q) lat_min_q <= lat_c;
            if (lat_c > lat_max_q) lat_max_q <= lat_c;
        end
    end

    assign out_lat_min = lat_min_q;
    assign out_lat_max = lat_max_q;
`else
    assign out_lat_min = '0;
    assign out_lat_max = '0;
`endif

endmodule

// File: tb/tb_codeword_latency_meter.sv
// Self-checking bench for codeword_latency_meter with a queue-based reference model.
module tb_codeword_latency_meter;

    localparam int unsigned CNT_LEN = 10;
    localparam int unsigned LAT_LEN = 20;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned PTR_LEN = 2;
    localparam int unsigned CLKC    = 1023;
    localparam int unsigned MASK    = 32'h000F_FFFF;
`ifdef LAT_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               in_Srst = 1'b1;
    logic               in_en = 1'b0;
    logic               in_clr = 1'b0;
    logic [CNT_LEN-1:0] in_clk_cnt = '0;
    logic [CNT_LEN-1:0] in_clk_cycle = '0;
    logic               in_start = 1'b0;
    logic               in_done = 1'b0;
    logic               out_lat_valid;
    logic [LAT_LEN-1:0] out_latency;
    logic [LAT_LEN-1:0] out_lat_min;
    logic [LAT_LEN-1:0] out_lat_max;
    logic [PTR_LEN:0]   out_inflight;
    logic               out_ovf;
    logic               out_udf;
    logic               out_fault;

    codeword_latency_meter #(
        .CNT_LEN (CNT_LEN),
        .CLK_CNT (CNT_LEN'(CLKC)),
        .LAT_LEN (LAT_LEN),
        .DEPTH   (DEPTH),
        .PTR_LEN (PTR_LEN)
    ) dut (
        .clk           (clk),
        .in_Srst       (in_Srst),
        .in_en         (in_en),
        .in_clr        (in_clr),
        .in_clk_cnt    (in_clk_cnt),
        .in_clk_cycle  (in_clk_cycle),
        .in_start      (in_start),
        .in_done       (in_done),
        .out_lat_valid (out_lat_valid),
        .out_latency   (out_latency),
        .out_lat_min   (out_lat_min),
        .out_lat_max   (out_lat_max),
        .out_inflight  (out_inflight),
        .out_ovf       (out_ovf),
        .out_udf       (out_udf),
        .out_fault     (out_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a queue of start stamps plus sticky flags.
    int unsigned mq[$];
    bit          m_valid, m_ovf, m_udf, m_fault;
    int unsigned m_lat, m_min, m_max;

    function automatic int unsigned exp_min();
        return MM ? m_min : 0;
    endfunction

    function automatic int unsigned exp_max();
        return MM ? m_max : 0;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, settle past it.
    task automatic step(input bit s, input bit d, input bit c, input bit e, input bit r,
                        input int unsigned cyc, input int unsigned cnt);
        int unsigned st;
        bit sv, dv;
        in_start = s; in_done = d; in_clr = c; in_en = e; in_Srst = r;
        in_clk_cycle = CNT_LEN'(cyc);
        in_clk_cnt   = CNT_LEN'(cnt);
        @(posedge clk);
        st = (cyc * CLKC + cnt) & MASK;
        sv = s && (cnt != 0);
        dv = d && (cnt != 0);
        m_valid = 1'b0;
        if (r) begin
            mq.delete();
            m_ovf = 0; m_udf = 0; m_fault = 0;
            m_lat = 0; m_min = MASK; m_max = 0;
        end else if (e) begin
            if (c) begin
                mq.delete();
                m_ovf = 0; m_udf = 0; m_fault = 0;
                m_min = MASK; m_max = 0;
            end else if (!m_fault) begin
                if (dv && mq.size() == 0) begin
                    m_udf = 1; m_fault = 1;
                end else if (sv && !dv && mq.size() == DEPTH) begin
                    m_ovf = 1; m_fault = 1;
                end else begin
                    if (dv) begin
                        m_lat = (st - mq.pop_front()) & MASK;
                        m_valid = 1'b1;
                        if (m_lat < m_min) m_min = m_lat;
                        if (m_lat > m_max) m_max = m_lat;
                    end
                    if (sv) mq.push_back(st);
                end
            end
        end
        #1;
        in_start = 0; in_done = 0; in_clr = 0; in_Srst = 0;
    endtask

    task automatic ev(input bit s, input bit d, input int unsigned stamp);
        step(s, d, 1'b0, 1'b1, 1'b0, stamp / CLKC, stamp % CLKC);
    endtask

    task automatic clr_step();
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1);
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (out_lat_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b exp 0", out_lat_valid); end
        n_cmp++; if (out_latency !== '0) begin n_bad++; $display("FAIL reset_latency got %0d exp 0", out_latency); end
        n_cmp++; if (out_lat_min !== LAT_LEN'(exp_min())) begin n_bad++; $display("FAIL reset_min got %0h exp %0h", out_lat_min, exp_min()); end
        n_cmp++; if (out_lat_max !== '0) begin n_bad++; $display("FAIL reset_max got %0d exp 0", out_lat_max); end
        n_cmp++; if (out_inflight !== '0) begin n_bad++; $display("FAIL reset_inflight got %0d exp 0", out_inflight); end
        n_cmp++; if ({out_ovf, out_udf, out_fault} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {out_ovf, out_udf, out_fault}); end
    endtask

    task automatic test_basic();
        step(1, 0, 0, 1, 0, 2, 10);
        n_cmp++; if (out_inflight !== 3'd1) begin n_bad++; $display("FAIL basic_inflight got %0d exp 1", out_inflight); end
        step(0, 1, 0, 1, 0, 3, 5);
        n_cmp++; if (out_lat_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %0b exp 1", out_lat_valid); end
        n_cmp++; if (out_latency !== LAT_LEN'(1018)) begin n_bad++; $display("FAIL basic_latency got %0d exp 1018", out_latency); end
        n_cmp++; if (out_lat_min !== LAT_LEN'(MM ? 1018 : 0)) begin n_bad++; $display("FAIL basic_min got %0d exp %0d", out_lat_min, MM ? 1018 : 0); end
        n_cmp++; if (out_lat_max !== LAT_LEN'(MM ? 1018 : 0)) begin n_bad++; $display("FAIL basic_max got %0d exp %0d", out_lat_max, MM ? 1018 : 0); end
        ev(0, 0, 100);
        n_cmp++; if (out_lat_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse_width got %0b exp 0", out_lat_valid); end
    endtask

    task automatic test_fifo_order();
        int unsigned starts[4] = '{10000, 20000, 30000, 40000};
        int unsigned lats[4]   = '{500, 700, 300, 900};
        clr_step();
        for (int i = 0; i < 4; i++) ev(1, 0, starts[i]);
        n_cmp++; if (out_inflight !== 3'd4) begin n_bad++; $display("FAIL order_full got %0d exp 4", out_inflight); end
        for (int i = 0; i < 4; i++) begin
            ev(0, 1, starts[i] + lats[i]);
            n_cmp++; if (out_lat_valid !== 1'b1 || out_latency !== LAT_LEN'(lats[i])) begin
                n_bad++; $display("FAIL order_lat%0d got v=%0b %0d exp v=1 %0d", i, out_lat_valid, out_latency, lats[i]);
            end
        end
        n_cmp++; if (out_lat_min !== LAT_LEN'(MM ? 300 : 0)) begin n_bad++; $display("FAIL order_min got %0d exp %0d", out_lat_min, MM ? 300 : 0); end
        n_cmp++; if (out_lat_max !== LAT_LEN'(MM ? 900 : 0)) begin n_bad++; $display("FAIL order_max got %0d exp %0d", out_lat_max, MM ? 900 : 0); end
        n_cmp++; if (out_inflight !== '0 || out_fault !== 1'b0) begin n_bad++; $display("FAIL order_drain got inflight=%0d fault=%0b exp 0 0", out_inflight, out_fault); end
    endtask

    task automatic test_overflow();
        clr_step();
        for (int i = 0; i < 5; i++) ev(1, 0, 2000 + 10 * i);
        n_cmp++; if (out_ovf !== 1'b1 || out_fault !== 1'b1) begin n_bad++; $display("FAIL ovf_flags got ovf=%0b fault=%0b exp 1 1", out_ovf, out_fault); end
        n_cmp++; if (out_inflight !== 3'd4) begin n_bad++; $display("FAIL ovf_inflight got %0d exp 4", out_inflight); end
        ev(0, 1, 3000);
        n_cmp++; if (out_lat_valid !== 1'b0 || out_inflight !== 3'd4) begin n_bad++; $display("FAIL ovf_done_ignored got v=%0b inflight=%0d exp 0 4", out_lat_valid, out_inflight); end
        clr_step();
        n_cmp++; if ({out_ovf, out_udf, out_fault} !== 3'b000 || out_inflight !== '0) begin n_bad++; $display("FAIL ovf_clr got flags=%b inflight=%0d exp 000 0", {out_ovf, out_udf, out_fault}, out_inflight); end
        n_cmp++; if (out_lat_min !== LAT_LEN'(exp_min()) || out_lat_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_clr_min got %0h v=%0b exp %0h v=0", out_lat_min, out_lat_valid, exp_min()); end
    endtask

    task automatic test_underflow();
        ev(1, 1, 5000);
        n_cmp++; if (out_udf !== 1'b1 || out_fault !== 1'b1 || out_ovf !== 1'b0) begin n_bad++; $display("FAIL udf_flags got udf=%0b fault=%0b ovf=%0b exp 1 1 0", out_udf, out_fault, out_ovf); end
        n_cmp++; if (out_inflight !== '0 || out_lat_valid !== 1'b0) begin n_bad++; $display("FAIL udf_inflight got %0d v=%0b exp 0 0", out_inflight, out_lat_valid); end
        clr_step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) ev(1, 0, 1000 + 100 * i);
        ev(1, 1, 1600);
        n_cmp++; if (out_lat_valid !== 1'b1 || out_latency !== LAT_LEN'(600)) begin n_bad++; $display("FAIL b2b_lat got v=%0b %0d exp v=1 600", out_lat_valid, out_latency); end
        n_cmp++; if (out_inflight !== 3'd4 || out_ovf !== 1'b0 || out_fault !== 1'b0) begin n_bad++; $display("FAIL b2b_state got inflight=%0d ovf=%0b fault=%0b exp 4 0 0", out_inflight, out_ovf, out_fault); end
        for (int i = 0; i < 4; i++) begin
            ev(0, 1, 2500 + 7 * i);
            n_cmp++; if (out_latency !== LAT_LEN'(m_lat) || out_lat_valid !== m_valid) begin n_bad++; $display("FAIL b2b_drain%0d got v=%0b %0d exp v=%0b %0d", i, out_lat_valid, out_latency, m_valid, m_lat); end
        end
    endtask

    task automatic test_srst_en();
        clr_step();
        for (int i = 0; i < 3; i++) ev(1, 0, 7000 + i);
        step(0, 0, 0, 1, 1, 0, 1);
        n_cmp++; if (out_inflight !== '0 || out_lat_valid !== 1'b0 || out_latency !== '0) begin n_bad++; $display("FAIL srst_state got inflight=%0d v=%0b lat=%0d exp 0 0 0", out_inflight, out_lat_valid, out_latency); end
        n_cmp++; if (out_lat_min !== LAT_LEN'(exp_min()) || out_lat_max !== '0 || {out_ovf, out_udf, out_fault} !== 3'b000) begin n_bad++; $display("FAIL srst_regs got min=%0h max=%0d flags=%b exp %0h 0 000", out_lat_min, out_lat_max, {out_ovf, out_udf, out_fault}, exp_min()); end
        ev(1, 0, 8000);
        step(0, 1, 0, 0, 0, 8100 / CLKC, 8100 % CLKC);
        n_cmp++; if (out_lat_valid !== 1'b0 || out_inflight !== 3'd1) begin n_bad++; $display("FAIL en_low got v=%0b inflight=%0d exp 0 1", out_lat_valid, out_inflight); end
        ev(0, 1, 8200);
        n_cmp++; if (out_lat_valid !== 1'b1 || out_latency !== LAT_LEN'(200)) begin n_bad++; $display("FAIL en_resume got v=%0b %0d exp 1 200", out_lat_valid, out_latency); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            bit s, d, c, e, r;
            int unsigned cyc, cnt;
            s = ($urandom_range(99) < 40);
            d = ($urandom_range(99) < 35);
            c = ($urandom_range(99) < 3);
            e = ($urandom_range(99) < 90);
            r = ($urandom_range(999) < 4);
            cyc = $urandom_range(1023);
            cnt = ($urandom_range(99) < 5) ? 0 : $urandom_range(1023, 1);
            step(s, d, c, e, r, cyc, cnt);
            n_cmp++;
            if (out_lat_valid !== m_valid || out_latency !== LAT_LEN'(m_lat) ||
                out_lat_min !== LAT_LEN'(exp_min()) || out_lat_max !== LAT_LEN'(exp_max()) ||
                out_inflight !== (PTR_LEN+1)'(mq.size()) ||
                {out_ovf, out_udf, out_fault} !== {m_ovf, m_udf, m_fault}) begin
                n_bad++;
                if (n_bad < 20)
                    $display("FAIL random_%0d got v=%0b lat=%0d min=%0d max=%0d inf=%0d f=%b exp v=%0b lat=%0d min=%0d max=%0d inf=%0d f=%b",
                             i, out_lat_valid, out_latency, out_lat_min, out_lat_max, out_inflight,
                             {out_ovf, out_udf, out_fault}, m_valid, m_lat, exp_min(), exp_max(),
                             mq.size(), {m_ovf, m_udf, m_fault});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_order();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_srst_en();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
